// File: rtl/compound_dispatcher.sv
// compound_dispatcher: folds input values into running-sum records {mode,x,y},
// buffers them in a FIFO and hands each one to N_CH blocking output channels
// (round-robin or broadcast). Every completed dispatch is mirrored on m_out.
module compound_dispatcher #(
    parameter  int X_W   = 8,
    parameter  int N_CH  = 4,
    parameter  int DEPTH = 4,
    localparam int REC_W = X_W + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [X_W-1:0]          in_sig,
    input  logic                    in_sync,
    output logic                    in_notify,
    input  logic                    cfg_bcast,
    output logic [N_CH*REC_W-1:0]   b_out,
    input  logic [N_CH-1:0]         b_out_sync,
    output logic [N_CH-1:0]         b_out_notify,
    output logic [REC_W-1:0]        m_out,
    output logic                    m_out_notify
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic {
        SEC_A,
        SEC_B
    } section_t;

    section_t               section, section_n;
    logic [X_W-1:0]         acc;
    logic [X_W:0]           sum;
    logic [REC_W-1:0]       new_rec;
    logic [REC_W-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic                   full, empty, push, pop;
    logic [PTR_W-1:0]       rr_ptr, rr_n;
    logic                   bcast, bcast_n;
    logic [REC_W-1:0]       cur_rec, cur_n;
    logic [N_CH*REC_W-1:0]  b_out_n;
    logic [N_CH-1:0]        notify_n;
    logic [REC_W-1:0]       m_out_n;
    logic                   m_pulse_n;

    // x is the low X_W bits of the sum, y its carry; mode follows x[0]
    assign sum       = {1'b0, acc} + {1'b0, in_sig};
    assign new_rec   = {sum[0], sum[X_W-1:0], sum[X_W]};
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_notify = !full;
    assign push      = in_sync && !full;
    assign pop       = (section == SEC_A) && !empty;

    // Record storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_rec;
        end
    end

    // FIFO pointers, occupancy and running accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            acc    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                acc    <= sum[X_W-1:0];
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Dispatch state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            section      <= SEC_A;
            rr_ptr       <= '0;
            bcast        <= 1'b0;
            cur_rec      <= '0;
            b_out        <= '0;
            b_out_notify <= '0;
            m_out        <= '0;
            m_out_notify <= 1'b0;
        end else begin
            section      <= section_n;
            rr_ptr       <= rr_n;
            bcast        <= bcast_n;
            cur_rec      <= cur_n;
            b_out        <= b_out_n;
            b_out_notify <= notify_n;
            m_out        <= m_out_n;
            m_out_notify <= m_pulse_n;
        end
    end

    // Load a record into the selected channel(s), then wait for every channel to take it
    always_comb begin
        section_n = section;
        rr_n      = rr_ptr;
        bcast_n   = bcast;
        cur_n     = cur_rec;
        b_out_n   = b_out;
        notify_n  = b_out_notify;
        m_out_n   = m_out;
        m_pulse_n = 1'b0;
        case (section)
            SEC_A: begin
                if (!empty) begin
                    cur_n   = mem[rd_ptr];
                    bcast_n = cfg_bcast;
                    for (int unsigned k = 0; k < N_CH; k++) begin
                        if (cfg_bcast || (PTR_W'(k) == rr_ptr)) begin
                            b_out_n[k*REC_W +: REC_W] = mem[rd_ptr];
                            notify_n[k]               = 1'b1;
                        end
                    end
                    section_n = SEC_B;
                end
            end
            SEC_B: begin
                notify_n = b_out_notify & ~b_out_sync;
                if (notify_n == '0) begin
                    m_out_n   = cur_rec;
                    m_pulse_n = 1'b1;
                    if (!bcast) begin
                        rr_n = (rr_ptr == PTR_W'(N_CH - 1)) ? '0 : rr_ptr + 1'b1;
                    end
                    section_n = SEC_A;
                end
            end
            default: section_n = SEC_A;
        endcase
    end

endmodule

// File: tb/tb_compound_dispatcher.sv
// Bench for compound_dispatcher: directed scenarios plus random traffic, checked
// against a queue-based reference model of the record stream and channel outputs.
module tb_compound_dispatcher;

    localparam int X_W   = 8;
    localparam int N_CH  = 4;
    localparam int DEPTH = 4;
    localparam int REC_W = X_W + 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [X_W-1:0]         in_sig = '0;
    logic                   in_sync = 1'b0;
    logic                   in_notify;
    logic                   cfg_bcast = 1'b0;
    logic [N_CH*REC_W-1:0]  b_out;
    logic [N_CH-1:0]        b_out_sync = '0;
    logic [N_CH-1:0]        b_out_notify;
    logic [REC_W-1:0]       m_out;
    logic                   m_out_notify;

    compound_dispatcher #(.X_W(X_W), .N_CH(N_CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_sig(in_sig), .in_sync(in_sync), .in_notify(in_notify),
        .cfg_bcast(cfg_bcast), .b_out(b_out), .b_out_sync(b_out_sync),
        .b_out_notify(b_out_notify), .m_out(m_out), .m_out_notify(m_out_notify)
    );

    always #5 clk = ~clk;

    int npass  = 0;
    int ntotal = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Record from the arithmetic rule: sum, wrap, carry, parity of x
    function automatic logic [REC_W-1:0] make_rec(input logic [X_W-1:0] a, input logic [X_W-1:0] v);
        int unsigned s, lim;
        logic [X_W-1:0] x;
        logic y, mode;
        lim  = 32'd1 << X_W;
        s    = 32'(a) + 32'(v);
        x    = X_W'(s % lim);
        y    = (s >= lim);
        mode = ((s % 2) == 1);
        return {mode, x, y};
    endfunction

    // Reference model state
    logic [REC_W-1:0]  fifo_q[$];
    logic [REC_W-1:0]  cur_rec;
    logic [REC_W-1:0]  shadow [N_CH];
    logic [N_CH-1:0]   notify_m, prev_sync, exp_n;
    logic [X_W-1:0]    acc_m;
    logic [REC_W-1:0]  pend_rec;
    bit                busy_m, pend_push, bc_next, cur_bc;
    int                rr_m;

    // Monitor: replays the edge that just happened in the model and compares every output
    always @(negedge clk) begin
        if (rst) begin
            fifo_q.delete();
            cur_rec = '0; notify_m = '0; acc_m = '0; busy_m = 0; pend_push = 0;
            rr_m = 0; bc_next = 0; cur_bc = 0;
            for (int k = 0; k < N_CH; k++) shadow[k] = '0;
            chk("rst_notify", 64'(b_out_notify), 64'(0));
            chk("rst_b_out", 64'(b_out), 64'(0));
            chk("rst_m_out", 64'(m_out), 64'(0));
            chk("rst_m_pulse", 64'(m_out_notify), 64'(0));
            chk("rst_in_notify", 64'(in_notify), 64'(1));
            prev_sync = b_out_sync;
        end else begin
            if (busy_m) begin
                notify_m = notify_m & ~prev_sync;
                chk("notify_clear", 64'(b_out_notify), 64'(notify_m));
                if (notify_m == '0) begin
                    chk("m_pulse", 64'(m_out_notify), 64'(1));
                    chk("m_out", 64'(m_out), 64'(cur_rec));
                    busy_m = 0;
                    if (!cur_bc) rr_m = (rr_m + 1) % N_CH;
                end else begin
                    chk("m_pulse_idle", 64'(m_out_notify), 64'(0));
                end
            end else begin
                chk("m_pulse_idle", 64'(m_out_notify), 64'(0));
                if (fifo_q.size() > 0) begin
                    cur_rec = fifo_q.pop_front();
                    cur_bc  = bc_next;
                    busy_m  = 1;
                    exp_n   = '0;
                    for (int k = 0; k < N_CH; k++) begin
                        if (cur_bc || k == rr_m) begin
                            exp_n[k]  = 1'b1;
                            shadow[k] = cur_rec;
                        end
                    end
                    notify_m = exp_n;
                    chk("load_notify", 64'(b_out_notify), 64'(exp_n));
                end else begin
                    chk("idle_notify", 64'(b_out_notify), 64'(0));
                end
            end
            for (int k = 0; k < N_CH; k++)
                chk("b_out_ch", 64'(b_out[k*REC_W +: REC_W]), 64'(shadow[k]));
            if (pend_push) fifo_q.push_back(pend_rec);
            chk("in_notify", 64'(in_notify), 64'(fifo_q.size() < DEPTH));
            pend_push = in_sync && (fifo_q.size() < DEPTH);
            if (pend_push) begin
                pend_rec = make_rec(acc_m, in_sig);
                acc_m    = pend_rec[REC_W-2:1];
            end
            prev_sync = b_out_sync;
            bc_next   = cfg_bcast;
        end
    end

    // Present one value and hold it until the block accepts it
    task automatic send(input logic [X_W-1:0] v);
        bit ok;
        int n;
        ok = 0;
        n  = 0;
        in_sig  = v;
        in_sync = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_notify;
            @(posedge clk);
            #1;
            n++;
        end
        in_sync = 1'b0;
        if (!ok) begin
            ntotal++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse landing mid-cycle
    task automatic pulse_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_notify", 64'(b_out_notify), 64'(0));
        chk("async_m_out", 64'(m_out), 64'(0));
        chk("async_in_notify", 64'(in_notify), 64'(1));
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        cycles(3);
        rst = 1'b0;

        // Round-robin, receivers always ready
        b_out_sync = '1;
        cfg_bcast  = 1'b0;
        send(8'h03);
        send(8'h05);
        send(8'hFF);
        cycles(8);
        chk("rr_last_m_out", 64'(m_out), 64'({1'b1, 8'h07, 1'b1}));

        // Broadcast with only channel 0 ready
        pulse_reset();
        cfg_bcast  = 1'b1;
        b_out_sync = 4'b0001;
        send(8'h04);
        cycles(2);
        chk("bcast_partial", 64'(b_out_notify), 64'(4'b1110));
        cycles(3);
        chk("bcast_blocked", 64'(m_out_notify), 64'(0));
        b_out_sync = '1;
        cfg_bcast  = 1'b0;
        cycles(2);
        chk("bcast_m_out", 64'(m_out), 64'({1'b0, 8'h04, 1'b0}));
        cycles(4);

        // Back-pressure until full, then release
        b_out_sync = '0;
        fork
            for (int i = 0; i < 6; i++) send(X_W'(8'h10 + 8'(i)));
            begin
                cycles(12);
                chk("full_block", 64'(in_notify), 64'(0));
                b_out_sync = '1;
            end
        join
        cycles(16);

        // Five round-robin records: pointer wraps
        for (int i = 0; i < 5; i++) send(X_W'($urandom));
        cycles(12);

        // Simultaneous pop and push with DEPTH-1 queued
        b_out_sync = '0;
        for (int i = 0; i < 4; i++) send(X_W'(8'h21 + 8'(i)));
        cycles(2);
        b_out_sync = '1;
        begin
            int n;
            n = 0;
            while (!m_out_notify && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("pp_complete_seen", 64'(m_out_notify), 64'(1));
        end
        in_sig     = 8'h5A;
        in_sync    = 1'b1;
        b_out_sync = '0;
        @(posedge clk);
        #1;
        in_sync = 1'b0;
        chk("pp_count_held", 64'(in_notify), 64'(1));
        cycles(2);
        b_out_sync = '1;
        cycles(16);

        // Reset in the middle of a blocked dispatch with two records queued
        b_out_sync = '0;
        send(8'h0A);
        send(8'h14);
        send(8'h1E);
        cycles(3);
        pulse_reset();
        b_out_sync = '1;
        send(8'h01);
        cycles(5);
        chk("post_rst_m_out", 64'(m_out), 64'({1'b1, 8'h01, 1'b0}));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_sync    = ($urandom_range(0, 2) != 0);
            in_sig     = X_W'($urandom);
            b_out_sync = N_CH'($urandom);
            cfg_bcast  = ($urandom_range(0, 3) == 0);
            cycles(1);
        end
        in_sync    = 1'b0;
        b_out_sync = '1;
        cycles(20);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
